// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single GPR write port: round-robin grant over ALU/load/muldiv,
// a registered register-file write stage, and a one-bit-per-register pending-write scoreboard.
module wb_arbiter #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [2:0]      req_valid,
  input  logic [14:0]     req_reg,
  input  logic [3*DW-1:0] req_data,
  output logic [2:0]      req_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_reg,
  input  logic [4:0]      q_rs,
  input  logic [4:0]      q_rt,
  output logic            busy_rs,
  output logic            busy_rt,
  output logic            rf_wen,
  output logic [4:0]      rf_wreg,
  output logic [DW-1:0]   rf_wdata
);

  logic [1:0]    ptr_q, ptr_d;
  logic          rf_wen_q, rf_wen_d;
  logic [4:0]    rf_wreg_q, rf_wreg_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic [31:0]   pend_q, pend_d;
  logic [2:0]    gnt;
  logic          xfer;
  logic [4:0]    win_reg;
  logic [DW-1:0] win_data;

  // Handshake: a requester transfers when req_valid[i] & req_ready[i]; it must hold
  // valid/reg/data stable until then. Grant depends only on req_valid and ptr.
  always_comb begin
    gnt = 3'b000;
    case (ptr_q)
      2'd1: begin
        if (req_valid[1])      gnt = 3'b010;
        else if (req_valid[2]) gnt = 3'b100;
        else if (req_valid[0]) gnt = 3'b001;
      end
      2'd2: begin
        if (req_valid[2])      gnt = 3'b100;
        else if (req_valid[0]) gnt = 3'b001;
        else if (req_valid[1]) gnt = 3'b010;
      end
      default: begin
        if (req_valid[0])      gnt = 3'b001;
        else if (req_valid[1]) gnt = 3'b010;
        else if (req_valid[2]) gnt = 3'b100;
      end
    endcase
    if (!resetn) gnt = 3'b000;
  end

  assign req_ready = gnt;
  assign xfer      = |gnt;

  always_comb begin
    win_reg  = req_reg[4:0];
    win_data = req_data[DW-1:0];
    ptr_d    = ptr_q;
    if (gnt[0]) ptr_d = 2'd1;
    if (gnt[1]) begin
      win_reg  = req_reg[9:5];
      win_data = req_data[2*DW-1:DW];
      ptr_d    = 2'd2;
    end
    if (gnt[2]) begin
      win_reg  = req_reg[14:10];
      win_data = req_data[3*DW-1:2*DW];
      ptr_d    = 2'd0;
    end
  end

  always_comb begin
    rf_wen_d   = xfer && (win_reg != 5'd0);
    rf_wreg_d  = xfer ? win_reg : rf_wreg_q;
    rf_wdata_d = xfer ? win_data : rf_wdata_q;
  end

  // Set is applied after clear so a re-issue to the register being committed stays pending.
  always_comb begin
    pend_d = pend_q;
    if (rf_wen_q) pend_d[rf_wreg_q] = 1'b0;
    if (iss_valid && (iss_reg != 5'd0)) pend_d[iss_reg] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q      <= 2'd0;
      rf_wen_q   <= 1'b0;
      rf_wreg_q  <= 5'd0;
      rf_wdata_q <= '0;
      pend_q     <= 32'd0;
    end else begin
      ptr_q      <= ptr_d;
      rf_wen_q   <= rf_wen_d;
      rf_wreg_q  <= rf_wreg_d;
      rf_wdata_q <= rf_wdata_d;
      pend_q     <= pend_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_wreg  = rf_wreg_q;
  assign rf_wdata = rf_wdata_q;
  assign busy_rs  = pend_q[q_rs];
  assign busy_rt  = pend_q[q_rt];

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inline checks on grants/busy plus a write-back scoreboard
// that expects one {wreg, wdata} entry per committed register-file write.
module tb_wb_arbiter;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            resetn;
  logic [2:0]      req_valid;
  logic [14:0]     req_reg;
  logic [3*DW-1:0] req_data;
  logic [2:0]      req_ready;
  logic            iss_valid;
  logic [4:0]      iss_reg, q_rs, q_rt;
  logic            busy_rs, busy_rt;
  logic            rf_wen;
  logic [4:0]      rf_wreg;
  logic [DW-1:0]   rf_wdata;

  logic [DW+4:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(.DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data), .req_ready(req_ready),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .q_rs(q_rs), .q_rt(q_rt),
    .busy_rs(busy_rs), .busy_rt(busy_rt),
    .rf_wen(rf_wen), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one-cycle request from requester idx; expects an immediate grant
  task automatic send(input int idx, input logic [4:0] r, input logic [DW-1:0] d,
                      input string name);
    logic [2:0] oh;
    oh = 3'b001 << idx;
    req_reg[5*idx +: 5]    = r;
    req_data[DW*idx +: DW] = d;
    req_valid = oh;
    #1;
    check(name, {61'd0, req_ready}, {61'd0, oh});
    if (r != 5'd0) exp_q.push_back({r, d});
    step();
    req_valid = 3'b000;
  endtask

  // monitor: every committed write must match the head of the expected queue
  always @(negedge clk) begin
    if (resetn && rf_wen) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got reg %0d data %0h expected no write", rf_wreg, rf_wdata);
      end else begin
        logic [DW+4:0] e;
        e = exp_q.pop_front();
        if ({rf_wreg, rf_wdata} !== e) begin
          n_err++;
          $display("FAIL wb_data: got reg %0d data %0h expected reg %0d data %0h",
                   rf_wreg, rf_wdata, e[DW+4:DW], e[DW-1:0]);
        end
      end
    end
  end

  logic [2:0] fv_tab [12] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                              3'b111, 3'b111, 3'b101, 3'b101, 3'b101, 3'b101};
  logic [2:0] fg_tab [12] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
                              3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};

  initial begin
    resetn = 1'b0; req_valid = 3'b111; req_reg = '0; req_data = '0;
    iss_valid = 1'b1; iss_reg = 5'd8; q_rs = 5'd8; q_rt = 5'd8;

    // reset with everything asserted
    step(); step(); step();
    check("rst_ready", {61'd0, req_ready}, 64'd0);
    check("rst_wen", {63'd0, rf_wen}, 64'd0);
    check("rst_wreg", {59'd0, rf_wreg}, 64'd0);
    check("rst_busy_rs", {63'd0, busy_rs}, 64'd0);
    check("rst_busy_rt", {63'd0, busy_rt}, 64'd0);
    iss_valid = 1'b0;
    resetn = 1'b1;
    #1;
    check("first_grant", {61'd0, req_ready}, 64'd1);
    req_valid = 3'b000;
    step();

    // single ALU write
    send(0, 5'd5, 32'h1234_5678, "single_ready");
    check("single_wen", {63'd0, rf_wen}, 64'd1);
    check("single_wreg", {59'd0, rf_wreg}, 64'd5);
    check("single_wdata", {32'd0, rf_wdata}, 64'h1234_5678);
    step();
    check("single_wen_drop", {63'd0, rf_wen}, 64'd0);

    // register 0: write accepted but not committed; issue to r0 never marks busy
    iss_valid = 1'b1; iss_reg = 5'd0; q_rs = 5'd0;
    send(1, 5'd0, 32'hFFFF_FFFF, "r0_ready");
    iss_valid = 1'b0;
    check("r0_wen", {63'd0, rf_wen}, 64'd0);
    check("r0_busy", {63'd0, busy_rs}, 64'd0);

    // scoreboard set then clear via muldiv write
    iss_valid = 1'b1; iss_reg = 5'd8; q_rs = 5'd8;
    #1;
    check("sb_busy_before", {63'd0, busy_rs}, 64'd0);
    step();
    iss_valid = 1'b0;
    check("sb_busy_set", {63'd0, busy_rs}, 64'd1);
    send(2, 5'd8, 32'hCAFE_0008, "sb_md_ready");
    check("sb_md_wen", {63'd0, rf_wen}, 64'd1);
    check("sb_busy_hold", {63'd0, busy_rs}, 64'd1);
    step();
    check("sb_busy_clear", {63'd0, busy_rs}, 64'd0);

    // set and clear of reg 9 on the same edge: set wins; different reg (7) cleared alongside
    iss_valid = 1'b1; iss_reg = 5'd9; q_rs = 5'd9; q_rt = 5'd7;
    step();
    iss_reg = 5'd7;
    step();
    iss_valid = 1'b0;
    check("sb9_set", {63'd0, busy_rs}, 64'd1);
    send(0, 5'd9, 32'h0000_0099, "sb9_ready");
    iss_valid = 1'b1; iss_reg = 5'd9;
    check("sb9_wen", {63'd0, rf_wen}, 64'd1);
    step();
    iss_valid = 1'b0;
    check("sb9_still_busy", {63'd0, busy_rs}, 64'd1);
    check("sb7_pending", {63'd0, busy_rt}, 64'd1);
    send(1, 5'd7, 32'h0000_0077, "sb7_ready");
    step();
    check("sb7_cleared", {63'd0, busy_rt}, 64'd0);
    check("sb9_unaffected", {63'd0, busy_rs}, 64'd1);

    // bring ptr from 2 back to 0 with a wrap-around grant
    send(2, 5'd4, 32'h0000_0044, "wrap_ready");

    // fairness
    req_reg  = {5'd3, 5'd2, 5'd1};
    req_data = {32'hC3C3_C3C3, 32'hB2B2_B2B2, 32'hA1A1_A1A1};
    for (int i = 0; i < 12; i++) begin
      req_valid = fv_tab[i];
      #1;
      check($sformatf("fair_%0d", i), {61'd0, req_ready}, {61'd0, fg_tab[i]});
      for (int k = 0; k < 3; k++)
        if (fg_tab[i][k]) exp_q.push_back({req_reg[5*k +: 5], req_data[DW*k +: DW]});
      step();
    end
    req_valid = 3'b000;
    step();

    // mid-operation reset with pend = 0x0F00 and a write in flight
    iss_valid = 1'b1; iss_reg = 5'd8;  step();
    iss_reg = 5'd10; step();
    iss_reg = 5'd11;
    send(0, 5'd12, 32'h0000_0C0C, "mid_ready");
    iss_valid = 1'b0;
    q_rs = 5'd8; q_rt = 5'd11;
    #1;
    check("mid_wen_pre", {63'd0, rf_wen}, 64'd1);
    check("mid_busy_rs_pre", {63'd0, busy_rs}, 64'd1);
    check("mid_busy_rt_pre", {63'd0, busy_rt}, 64'd1);
    #5;
    req_valid = 3'b111;
    resetn = 1'b0;
    #1;
    check("mid_wen", {63'd0, rf_wen}, 64'd0);
    check("mid_wreg", {59'd0, rf_wreg}, 64'd0);
    check("mid_wdata", {32'd0, rf_wdata}, 64'd0);
    check("mid_busy_rs", {63'd0, busy_rs}, 64'd0);
    check("mid_busy_rt", {63'd0, busy_rt}, 64'd0);
    check("mid_ready", {61'd0, req_ready}, 64'd0);
    step();
    req_valid = 3'b000;
    resetn = 1'b1;
    step(); step();

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
